// File: rtl/uart_rx_oversampled_pkg.sv
// Shared UART definitions: receiver state encoding, baud divider helper, frame width.
`timescale 1ns/1ps
package uart_pkg;

  localparam int unsigned UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } rx_state_t;

  // Clocks per oversample tick, rounded to nearest.
  function automatic int unsigned calc_div(input int unsigned clk_hz,
                                           input int unsigned baud,
                                           input int unsigned os);
    int unsigned den;
    den = baud * os;
    return (clk_hz + den / 2) / den;
  endfunction

endpackage

// File: rtl/uart_rx_oversampled_baud_tick_gen.sv
// Free-running oversample tick divider; clear restarts the phase at zero.
`timescale 1ns/1ps
module baud_tick_gen #(
  parameter int unsigned DIV = 27
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = !clear && (cnt == LAST);

endmodule

// File: rtl/uart_rx_oversampled.sv
// 8N1 UART receiver: 2-FF synchroniser, oversampled 3-sample majority vote,
// false-start rejection and framing-error detection with break lockout.
`timescale 1ns/1ps
module uart_rx_oversampled
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      rx,
  output logic                      rxReady,
  output logic [UART_DATA_BITS-1:0] rxData,
  output logic                      rxFramingError,
  output logic                      rxBusy
);

  localparam int unsigned DIV = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int unsigned SW  = $clog2(OVERSAMPLE);
  localparam int unsigned IW  = $clog2(UART_DATA_BITS);

  localparam logic [SW-1:0] S_V0   = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_V1   = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] S_DEC  = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [IW-1:0] I_LAST = IW'(UART_DATA_BITS - 1);

  logic                      rx_meta;
  logic                      rxs;
  rx_state_t                 state;
  logic [SW-1:0]             s;
  logic [IW-1:0]             bit_idx;
  logic [UART_DATA_BITS-1:0] shift;
  logic                      v0;
  logic                      v1;
  logic                      tick;
  logic                      clear;
  logic                      vote;
  logic                      at_dec;
  logic                      at_wrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  // Bit phase is re-anchored to the detected start edge.
  assign clear = (state == IDLE) && !rxs;

  baud_tick_gen #(.DIV(DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .tick  (tick)
  );

  assign vote    = (v0 & v1) | (v0 & rxs) | (v1 & rxs);
  assign at_dec  = tick && (s == S_DEC);
  assign at_wrap = tick && (s == S_LAST);

  always_comb begin
    rxBusy = (state == START) || (state == DATA) || (state == STOP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      s              <= '0;
      bit_idx        <= '0;
      shift          <= '0;
      v0             <= 1'b1;
      v1             <= 1'b1;
      rxReady        <= 1'b0;
      rxFramingError <= 1'b0;
      rxData         <= '0;
    end else begin
      rxReady        <= 1'b0;
      rxFramingError <= 1'b0;

      if (tick && state != IDLE) begin
        if (s == S_V0) v0 <= rxs;
        if (s == S_V1) v1 <= rxs;
      end

      unique case (state)
        IDLE: begin
          if (!rxs) begin
            state <= START;
            s     <= '0;
          end
        end
        START: begin
          if (tick) s <= (s == S_LAST) ? '0 : s + 1'b1;
          if (at_dec && vote) begin
            state <= IDLE;
          end else if (at_wrap) begin
            state   <= DATA;
            bit_idx <= '0;
          end
        end
        DATA: begin
          if (tick) s <= (s == S_LAST) ? '0 : s + 1'b1;
          if (at_dec) shift <= {vote, shift[UART_DATA_BITS-1:1]};
          if (at_wrap) begin
            if (bit_idx == I_LAST) state <= STOP;
            else                   bit_idx <= bit_idx + 1'b1;
          end
        end
        STOP: begin
          if (tick) s <= (s == S_LAST) ? '0 : s + 1'b1;
          // Leave at the stop-bit centre so a fast sender's next start edge is not missed.
          if (at_dec) begin
            if (vote) begin
              rxData  <= shift;
              rxReady <= 1'b1;
              state   <= IDLE;
            end else begin
              rxFramingError <= 1'b1;
              state          <= WAIT_IDLE;
              s              <= '0;
            end
          end
        end
        WAIT_IDLE: begin
          if (!rxs) begin
            s <= '0;
          end else if (tick) begin
            if (s == S_LAST) state <= IDLE;
            else             s <= s + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Directed + randomized bench for uart_rx_oversampled against a frame-level expectation model.
`timescale 1ns/1ps
module tb_uart_rx_oversampled;

  // Clock rate chosen so one oversample tick is exactly 4 clk (short simulation).
  localparam int unsigned BAUD     = 115200;
  localparam int unsigned OS       = 16;
  localparam int unsigned CLK_HZ   = BAUD * OS * 4;
  localparam real         CLK_NS   = 10.0;
  localparam int          BIT_CLKS = 4 * OS;
  localparam real         BIT_NS   = CLK_NS * BIT_CLKS;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       rxReady;
  logic [7:0] rxData;
  logic       rxFramingError;
  logic       rxBusy;

  always #5 clk = ~clk;

  uart_rx_oversampled #(
    .CLK_HZ     (CLK_HZ),
    .BAUD       (BAUD),
    .OVERSAMPLE (OS)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rx             (rx),
    .rxReady        (rxReady),
    .rxData         (rxData),
    .rxFramingError (rxFramingError),
    .rxBusy         (rxBusy)
  );

  int   vectors = 0;
  int   miscompares = 0;

  bit [7:0] got[$];
  int       ferr = 0;
  int       overlap = 0;
  int       consec = 0;
  logic     prev_pulse = 1'b0;

  always @(negedge clk) begin
    if (rxReady) got.push_back(rxData);
    if (rxFramingError) ferr <= ferr + 1;
    if (rxReady && rxFramingError) overlap <= overlap + 1;
    if ((rxReady || rxFramingError) && prev_pulse) consec <= consec + 1;
    prev_pulse <= rxReady || rxFramingError;
  end

  bit [7:0] exp_q[$];
  int       exp_ferr = 0;
  bit [7:0] last_good = 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Frame-level model: a frame within tolerance with a high stop bit yields its byte,
  // a low stop bit yields one framing error and no byte.
  task automatic model_frame(input bit [7:0] b, input bit stop_val);
    if (stop_val) begin
      exp_q.push_back(b);
      last_good = b;
    end else begin
      exp_ferr++;
    end
  endtask

  task automatic send_frame(input bit [7:0] b, input real bit_ns, input bit stop_val,
                            input int spike_bit);
    bit [9:0] fr;
    fr = {stop_val, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = fr[i];
      if (spike_bit >= 0 && i == spike_bit + 1) begin
        #(bit_ns / 2.0 - 2.0 * CLK_NS);
        rx = ~fr[i];
        #(4.0 * CLK_NS);
        rx = fr[i];
        #(bit_ns / 2.0 - 2.0 * CLK_NS);
      end else begin
        #(bit_ns);
      end
    end
  endtask

  task automatic align();
    @(posedge clk);
    #2;
  endtask

  task automatic settle_and_compare(input string tag);
    int n;
    int m;
    n = 0;
    while (got.size() < exp_q.size() && n < 40 * BIT_CLKS) begin
      @(negedge clk);
      n++;
    end
    repeat (2 * BIT_CLKS) @(negedge clk);
    check({tag, "_count"}, got.size(), exp_q.size());
    m = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < m; i++) check({tag, "_data"}, got[i], exp_q[i]);
    check({tag, "_ferr"}, ferr, exp_ferr);
    got.delete();
    exp_q.delete();
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit [7:0] b2b[4];
    b2b = '{8'h00, 8'hFF, 8'hA5, 8'h5A};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ready", rxReady, 1'b0);
    check("rst_data", rxData, 8'h00);
    check("rst_ferr", rxFramingError, 1'b0);
    check("rst_busy", rxBusy, 1'b0);
    rst_n = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge clk);
    check("idle_busy", rxBusy, 1'b0);

    // Single frame at nominal rate
    align();
    send_frame(8'h17, BIT_NS, 1'b1, -1);
    model_frame(8'h17, 1'b1);
    settle_and_compare("single");
    check("single_hold", rxData, 8'h17);

    // Back-to-back frames, no idle gap
    align();
    foreach (b2b[i]) begin
      send_frame(b2b[i], BIT_NS, 1'b1, -1);
      model_frame(b2b[i], 1'b1);
    end
    settle_and_compare("b2b");

    // Sender clock skew
    align();
    send_frame(8'h3C, BIT_NS / 1.025, 1'b1, -1);
    model_frame(8'h3C, 1'b1);
    settle_and_compare("fast");
    align();
    send_frame(8'h3C, BIT_NS / 0.975, 1'b1, -1);
    model_frame(8'h3C, 1'b1);
    settle_and_compare("slow");

    // Short low glitch: start seen, then rejected
    align();
    rx = 1'b0;
    #(8.0 * CLK_NS);
    check("glitch_busy_hi", rxBusy, 1'b1);
    #(8.0 * CLK_NS);
    rx = 1'b1;
    settle_and_compare("glitch");
    check("glitch_busy_lo", rxBusy, 1'b0);

    // Framing error, line held low, then recovery
    align();
    send_frame(8'h42, BIT_NS, 1'b0, -1);
    model_frame(8'h42, 1'b0);
    #(3.0 * BIT_NS);
    check("fe_pulse", ferr, exp_ferr);
    check("fe_hold", rxData, last_good);
    check("fe_nobyte", got.size(), 0);
    check("fe_wait_busy", rxBusy, 1'b0);
    rx = 1'b1;
    #(2.0 * BIT_NS);
    send_frame(8'h81, BIT_NS, 1'b1, -1);
    model_frame(8'h81, 1'b1);
    settle_and_compare("fe_recover");

    // One-sample spike in the middle of data bit 3
    align();
    send_frame(8'h00, BIT_NS, 1'b1, 3);
    model_frame(8'h00, 1'b1);
    settle_and_compare("spike");

    // Reset asserted mid-frame, held until the line is idle again
    check("pre_rst_data", rxData, 8'h00);
    align();
    send_frame(8'h81, BIT_NS, 1'b1, -1);
    model_frame(8'h81, 1'b1);
    settle_and_compare("pre_rst");
    align();
    fork
      send_frame(8'h99, BIT_NS, 1'b1, -1);
      begin
        #(5.5 * BIT_NS);
        rst_n = 1'b0;
        #(3.0 * CLK_NS);
        check("midrst_data", rxData, 8'h00);
        check("midrst_busy", rxBusy, 1'b0);
        #(5.0 * BIT_NS);
        rst_n = 1'b1;
      end
    join
    settle_and_compare("midrst");
    check("midrst_after", rxData, 8'h00);
    align();
    send_frame(8'h07, BIT_NS, 1'b1, -1);
    model_frame(8'h07, 1'b1);
    settle_and_compare("post_rst");

    // Random bytes, skew within +/-2 %, gaps of 0..2 bit times
    align();
    for (int i = 0; i < 8; i++) begin
      bit [7:0] b;
      real      skew;
      b    = 8'($urandom_range(0, 255));
      skew = 1.0 + (real'($urandom_range(0, 40)) - 20.0) / 1000.0;
      send_frame(b, BIT_NS / skew, 1'b1, -1);
      model_frame(b, 1'b1);
      #(real'($urandom_range(0, 2)) * BIT_NS);
    end
    settle_and_compare("rand");

    check("pulse_overlap", overlap, 0);
    check("pulse_consec", consec, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
